// File: rtl/cache_stats_unit.sv
// Fixed-point L1/L2 miss-rate calculator: misses / (hits + misses) as unsigned Q0.FRAC_W,
// using one serial restoring divider shared between the two cache levels.
module cache_stats_unit #(
    parameter int unsigned CNT_W  = 18,
    parameter int unsigned FRAC_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  L1_hits,
    input  logic [CNT_W-1:0]  L1_misses,
    input  logic [CNT_W-1:0]  L2_hits,
    input  logic [CNT_W-1:0]  L2_misses,
    output logic              busy,
    output logic              done,
    output logic [FRAC_W-1:0] L1_miss_rate,
    output logic [FRAC_W-1:0] L2_miss_rate,
    output logic              L1_zero,
    output logic              L2_zero
);

    localparam int unsigned DEN_W = CNT_W + 1;
    localparam int unsigned REM_W = CNT_W + 2;
    localparam int unsigned IT_W  = $clog2(FRAC_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV_L1 = 2'd1,
        DIV_L2 = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [REM_W-1:0]   rem;
    logic [DEN_W-1:0]   denom;
    logic [DEN_W-1:0]   l2_denom;
    logic [CNT_W-1:0]   l2_miss;
    logic               l1_zero_snap;
    logic               l2_zero_snap;
    logic [IT_W-1:0]    iter;
    logic [FRAC_W-1:0]  quot;
    logic [FRAC_W-1:0]  l1_quot;

    logic [DEN_W-1:0]   l1_denom_c;
    logic [DEN_W-1:0]   l2_denom_c;
    logic [REM_W-1:0]   rem_sh_c;
    logic               rem_ge_c;
    logic [REM_W-1:0]   rem_nxt_c;
    logic [FRAC_W-1:0]  quot_nxt_c;
    logic               last_iter_c;

    // Denominators are one bit wider than the counters so they cannot overflow.
    assign l1_denom_c = DEN_W'(L1_hits) + DEN_W'(L1_misses);
    assign l2_denom_c = DEN_W'(L2_hits) + DEN_W'(L2_misses);

    // One restoring-division step; quotient bits enter at the LSB so the first is the MSB.
    assign rem_sh_c    = rem << 1;
    assign rem_ge_c    = rem_sh_c >= REM_W'(denom);
    assign rem_nxt_c   = rem_ge_c ? (rem_sh_c - REM_W'(denom)) : rem_sh_c;
    assign quot_nxt_c  = {quot[FRAC_W-2:0], rem_ge_c};
    assign last_iter_c = (iter == IT_W'(FRAC_W - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)       state_d = DIV_L1;
            DIV_L1:  if (last_iter_c) state_d = DIV_L2;
            DIV_L2:  if (last_iter_c) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            L1_miss_rate <= '0;
            L2_miss_rate <= '0;
            L1_zero      <= 1'b0;
            L2_zero      <= 1'b0;
            rem          <= '0;
            denom        <= '0;
            l2_denom     <= '0;
            l2_miss      <= '0;
            l1_zero_snap <= 1'b0;
            l2_zero_snap <= 1'b0;
            iter         <= '0;
            quot         <= '0;
            l1_quot      <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem          <= REM_W'(L1_misses);
                        denom        <= l1_denom_c;
                        l2_denom     <= l2_denom_c;
                        l2_miss      <= L2_misses;
                        l1_zero_snap <= (l1_denom_c == '0);
                        l2_zero_snap <= (l2_denom_c == '0);
                        iter         <= '0;
                        quot         <= '0;
                    end
                end
                DIV_L1: begin
                    iter <= iter + IT_W'(1);
                    rem  <= rem_nxt_c;
                    quot <= quot_nxt_c;
                    if (last_iter_c) begin
                        // Hand the divider over to L2 on the same edge as the last L1 step.
                        l1_quot <= l1_zero_snap ? '0 : quot_nxt_c;
                        rem     <= REM_W'(l2_miss);
                        denom   <= l2_denom;
                        iter    <= '0;
                        quot    <= '0;
                    end
                end
                DIV_L2: begin
                    iter <= iter + IT_W'(1);
                    rem  <= rem_nxt_c;
                    quot <= quot_nxt_c;
                    if (last_iter_c) begin
                        L1_miss_rate <= l1_quot;
                        L2_miss_rate <= l2_zero_snap ? '0 : quot_nxt_c;
                        L1_zero      <= l1_zero_snap;
                        L2_zero      <= l2_zero_snap;
                        done         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_stats_unit.sv
// Scoreboard bench for cache_stats_unit: stimulus pushes expected results, a monitor
// pops and checks them (values and completion cycle) whenever done is seen.
module tb_cache_stats_unit;

    localparam int unsigned CNT_W  = 18;
    localparam int unsigned FRAC_W = 16;
    localparam int unsigned LAT    = 2 * FRAC_W;

    typedef struct {
        logic [FRAC_W-1:0] l1_rate;
        logic [FRAC_W-1:0] l2_rate;
        logic              l1_z;
        logic              l2_z;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  l1_hits, l1_misses, l2_hits, l2_misses;
    logic              busy, done;
    logic [FRAC_W-1:0] l1_rate, l2_rate;
    logic              l1_z, l2_z;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    cache_stats_unit #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .L1_hits      (l1_hits),
        .L1_misses    (l1_misses),
        .L2_hits      (l2_hits),
        .L2_misses    (l2_misses),
        .busy         (busy),
        .done         (done),
        .L1_miss_rate (l1_rate),
        .L2_miss_rate (l2_rate),
        .L1_zero      (l1_z),
        .L2_zero      (l2_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("l1_rate", 32'(l1_rate), 32'(e.l1_rate));
                chk("l2_rate", 32'(l2_rate), 32'(e.l2_rate));
                chk("l1_zero", 32'(l1_z), 32'(e.l1_z));
                chk("l2_zero", 32'(l2_z), 32'(e.l2_z));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic push(input logic [FRAC_W-1:0] r1, input logic [FRAC_W-1:0] r2,
                        input logic z1, input logic z2, input int c);
        exp_t e;
        e.l1_rate = r1; e.l2_rate = r2; e.l1_z = z1; e.l2_z = z2; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Drive counters and a one-cycle start; returns the cycle number of the accepting edge.
    task automatic do_start(input logic [CNT_W-1:0] h1, input logic [CNT_W-1:0] m1,
                            input logic [CNT_W-1:0] h2, input logic [CNT_W-1:0] m2,
                            output int acc);
        @(negedge clk);
        l1_hits = h1; l1_misses = m1; l2_hits = h2; l2_misses = m2;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic drain(input string nm);
        repeat (LAT + 4) @(negedge clk);
        chk(nm, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input string nm,
                           input logic [CNT_W-1:0] h1, input logic [CNT_W-1:0] m1,
                           input logic [CNT_W-1:0] h2, input logic [CNT_W-1:0] m2,
                           input logic [FRAC_W-1:0] r1, input logic [FRAC_W-1:0] r2,
                           input logic z1, input logic z2);
        int acc;
        do_start(h1, m1, h2, m2, acc);
        push(r1, r2, z1, z2, acc + LAT);
        drain(nm);
    endtask

    initial begin
        int acc;
        reset = 1'b1; start = 1'b0;
        l1_hits = '0; l1_misses = '0; l2_hits = '0; l2_misses = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rates", 32'({l1_rate, l2_rate}), 32'd0);
        chk("rst_zero", 32'({l1_z, l2_z}), 32'd0);
        reset = 1'b0;

        run_vec("t1_pending", 18'd3, 18'd1, 18'd2, 18'd1, 16'h4000, 16'h5555, 1'b0, 1'b0);
        run_vec("t2_pending", 18'd0, 18'd5, 18'd0, 18'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        run_vec("t3_pending", 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'd0,
                16'h8000, 16'h0000, 1'b0, 1'b0);
        run_vec("t3b_pending", 18'd1, 18'd2, 18'd7, 18'd1, 16'hAAAA, 16'h2000, 1'b0, 1'b0);
        run_vec("t3c_pending", 18'd0, 18'd0, 18'd0, 18'd9, 16'h0000, 16'hFFFF, 1'b1, 1'b0);

        // Start while busy must be ignored and inputs must not disturb the snapshot.
        do_start(18'd3, 18'd1, 18'd2, 18'd1, acc);
        push(16'h4000, 16'h5555, 1'b0, 1'b0, acc + LAT);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        l1_hits = 18'd0; l1_misses = 18'd7; l2_hits = 18'd0; l2_misses = 18'd0;
        @(posedge clk);
        #1 start = 1'b0;
        chk("t4_busy_mid", 32'(busy), 32'd1);
        drain("t4_pending");

        // Reset mid-computation aborts with no done and clears outputs.
        run_vec("t5_pre_pending", 18'd1, 18'd2, 18'd7, 18'd1, 16'hAAAA, 16'h2000, 1'b0, 1'b0);
        do_start(18'd3, 18'd1, 18'd2, 18'd1, acc);
        repeat (18) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_rates", 32'({l1_rate, l2_rate}), 32'd0);
        chk("t5_zero", 32'({l1_z, l2_z}), 32'd0);
        drain("t5_abort_pending");
        run_vec("t5_restart_pending", 18'd3, 18'd1, 18'd2, 18'd1, 16'h4000, 16'h5555, 1'b0, 1'b0);

        // start held high: back-to-back results every LAT+1 cycles.
        @(negedge clk);
        l1_hits = 18'd7; l1_misses = 18'd1; l2_hits = 18'd1; l2_misses = 18'd2;
        start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        for (int k = 0; k < 3; k++) push(16'h2000, 16'hAAAA, 1'b0, 1'b0, acc + LAT + k * (LAT + 1));
        repeat (2 * (LAT + 1)) @(posedge clk);
        #1 start = 1'b0;
        drain("t6_pending");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_stats_unit.md
# cache_stats_unit

Post-run statistics stage that sits directly downstream of `cache_engine`. It consumes the L1/L2 hit and miss counters and produces fixed-point miss rates, `misses / (hits + misses)`, in hardware. A serial restoring divider is shared between the two cache levels. This replaces the real-valued miss-rate arithmetic currently done in the bench, so the rates are synthesizable and observable on the FPGA.

## Interface
Parameters:
- `CNT_W`, 18, width of each hit/miss counter input; matches `cache_engine` counter width.
- `FRAC_W`, 16, number of fractional bits in each miss-rate output (unsigned Q0.`FRAC_W`).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a computation; sampled only in IDLE.
- `L1_hits`  in  `CNT_W`  L1 hit counter from `cache_engine`.
- `L1_misses`  in  `CNT_W`  L1 miss counter from `cache_engine`.
- `L2_hits`  in  `CNT_W`  L2 hit counter from `cache_engine`.
- `L2_misses`  in  `CNT_W`  L2 miss counter from `cache_engine`.
- `busy`  out  1  high from acceptance of `start` until the result is written.
- `done`  out  1  one-cycle pulse when new results are valid.
- `L1_miss_rate`  out  `FRAC_W`  floor(L1_misses·2^FRAC_W / (L1_hits+L1_misses)).
- `L2_miss_rate`  out  `FRAC_W`  same calculation for L2.
- `L1_zero`  out  1  L1 denominator was 0 in the last computation.
- `L2_zero`  out  1  L2 denominator was 0 in the last computation.

## Operation
- **FSM states:** IDLE, DIV_L1, DIV_L2.
  - IDLE → DIV_L1 on `start`.
  - DIV_L1 → DIV_L2 after `FRAC_W` iterations.
  - DIV_L2 → IDLE after `FRAC_W` iterations.
- **Snapshot:** on the edge that accepts `start`, latch all four counters. Input changes while `busy` are ignored.
- **Denominator:** `hits + misses`, computed at `CNT_W+1` bits. It never overflows.
- **Remainder register:** `CNT_W+2` bits, initialised to `misses`.
- **Each iteration (restoring division):**
  - `rem = rem << 1`.
  - If `rem >= denom`, then `rem -= denom` and the quotient bit is 1; otherwise the quotient bit is 0.
  - Quotient bits are produced MSB first.
- **misses == denom (rate 1.0):** the algorithm yields all ones (0xFFFF for `FRAC_W`=16). This is the required saturated value; no special case is added.
- **Zero denominator (denom == 0):**
  - The quotient is forced to 0 and the matching `_zero` flag is set.
  - The iteration count is unchanged, so latency is data-independent.
- **Result holding:** L1 and L2 quotients are held internally. Both output rates, and both `_zero` flags, update together on the final edge, so outputs are always a coherent pair.
- **start while busy:** ignored. It is neither queued nor able to restart the computation.

## Timing
- **Acceptance:** `start` is sampled high in IDLE at edge N.
  - `busy`=1 after edge N.
  - L1 iterations run on edges N+1..N+`FRAC_W`.
  - L2 iterations run on edges N+`FRAC_W`+1..N+2·`FRAC_W`.
- **Completion, at edge N+2·`FRAC_W`:**
  - Outputs are written and `done`=1 for exactly one cycle.
  - `busy`=0 and the FSM returns to IDLE.
  - Latency is 32 cycles for the defaults.
- **Back-to-back:** `start` held high is accepted again at edge N+2·`FRAC_W`+1, giving continuous operation with no dead cycle beyond the `done` cycle.
- **Reset values:** `busy`=0, `done`=0, both rates=0, both `_zero` flags=0, FSM=IDLE.
- **Reset mid-operation:** abort to IDLE with no `done` pulse. Outputs return to the reset values.
- **Reset and start in the same cycle:** reset wins.

## Test plan
1. L1 hits=3, misses=1; L2 hits=2, misses=1; pulse `start` → `done` 32 cycles later; L1_miss_rate=0x4000, L2_miss_rate=0x5555; both `_zero` flags=0.
2. L1 hits=0, misses=5; L2 hits=0, misses=0 → L1_miss_rate=0xFFFF, L1_zero=0; L2_miss_rate=0x0000, L2_zero=1.
3. L1 hits=0x3FFFF, misses=0x3FFFF; L2 hits=0x3FFFF, misses=0 → L1_miss_rate=0x8000, L2_miss_rate=0x0000; no overflow.
4. Start a computation, then pulse `start` again and change all counters at cycle 10 → exactly one `done`, at cycle 32, with results from the original snapshot.
5. Assert `reset` at cycle 20 of a computation → no `done`; `busy`=0 and all outputs 0 the next cycle; a fresh `start` then completes normally.
6. Hold `start` high continuously with constant inputs → `done` pulses every 33 cycles with identical results.
